// File: rtl/axi_master_pkg.sv
// Shared types and helpers for the AXI burst write initiator.
// Holds the FSM state encoding, AXI response codes and the burst sizing helper.
package axi_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Beats in the next burst: the smaller of what is left and the burst cap.
  function automatic logic [8:0] burst_min(input logic [31:0] remaining,
                                           input logic [31:0] max_burst);
    logic [31:0] r;
    r = (remaining < max_burst) ? remaining : max_burst;
    return r[8:0];
  endfunction

endpackage

// File: rtl/axi_burst_write_master.sv
// Moves a linear block of stream words into AXI memory as INCR bursts,
// one burst outstanding at a time (AW, then W beats, then B).
module axi_burst_write_master
  import axi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  total_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output state_t                dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid && ready; a raised valid (and its payload) is never made to
  // depend on ready. W is a straight pass-through of the input stream.

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining, rem_after;
  logic [8:0]            burst_len, nxt_len;
  logic [7:0]            len_m1, beat_cnt;
  logic                  in_data, w_fire;

  assign in_data   = (state == DATA);
  assign busy      = (state != IDLE);
  assign awvalid   = (state == ADDR);
  assign awaddr    = cur_addr;
  assign awlen     = len_m1;
  assign wvalid    = in_data && s_valid;
  assign wdata     = in_data ? s_data : '0;
  assign s_ready   = in_data && wready;
  assign wlast     = in_data && (beat_cnt == 8'd0);
  assign bready    = (state == RESP);
  assign dbg_state = state;
  assign w_fire    = wvalid && wready;

  assign rem_after = remaining - LEN_WIDTH'(burst_len);
  // Length of the burst about to enter ADDR, from a fresh command or the remainder.
  assign nxt_len   = burst_min(32'((state == IDLE) ? total_beats : rem_after),
                               32'(MAX_BURST));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (total_beats != '0)) state_nxt = ADDR;
      ADDR:    if (awready) state_nxt = DATA;
      DATA:    if (w_fire && wlast) state_nxt = RESP;
      RESP:    if (bvalid) state_nxt = (rem_after == '0) ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      burst_len <= '0;
      len_m1    <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= total_beats;
            error     <= 1'b0;
            if (total_beats == '0) begin
              done <= 1'b1;
            end else begin
              burst_len <= nxt_len;
              len_m1    <= 8'(nxt_len - 9'd1);
            end
          end
        end
        ADDR: if (awready) beat_cnt <= len_m1;
        DATA: if (w_fire) beat_cnt <= beat_cnt - 8'd1;
        RESP: begin
          if (bvalid) begin
            // A failed burst is only recorded; the rest of the block still goes out.
            if (bresp != AXI_RESP_OKAY) error <= 1'b1;
            remaining <= rem_after;
            cur_addr  <= cur_addr + ADDR_WIDTH'(burst_len);
            if (rem_after == '0) begin
              done <= 1'b1;
            end else begin
              burst_len <= nxt_len;
              len_m1    <= 8'(nxt_len - 9'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
AXI write-side initiator that moves a linear block of words from an internal valid/ready stream into the 3-channel AXI memory slave.
- Accepts a command (start word address, total beat count) and splits it into INCR bursts of at most MAX_BURST beats.
- Drives the AW, W and B channels in sequence, one burst outstanding at a time.
- Sits between image-processing producers and the shared frame memory.

Parameters:
ADDR_WIDTH, 32, word address width (address increments by 1 per beat)
DATA_WIDTH, 32, data beat width
MAX_BURST, 16, max beats per burst (1..256)
LEN_WIDTH, 16, width of total beat count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, accepted only when busy=0
start_addr  in  ADDR_WIDTH  first word address
total_beats  in  LEN_WIDTH  beats to write (0 allowed)
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
error  out  1  sticky: some burst returned bresp!=OKAY
s_data  in  DATA_WIDTH  stream data
s_valid  in  1  stream valid
s_ready  out  1  stream ready
awaddr  out  ADDR_WIDTH  burst start address
awlen  out  8  beats-1
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DATA_WIDTH  write data
wlast  out  1  last beat of burst
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  write response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; FSM in IDLE; counters and address 0.
- Reset mid-operation: the FSM returns to IDLE immediately. No done pulse; error is cleared.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - start=1 latches cur_addr=start_addr and remaining=total_beats, and clears error.
  - If total_beats==0: stay in IDLE and pulse done next cycle, with no AXI traffic.
  - Otherwise go to ADDR with busy=1.
  - start while busy=1 is ignored.
- ADDR:
  - burst_len = min(remaining, MAX_BURST), registered on entry.
  - awvalid=1, awaddr=cur_addr, awlen=burst_len-1. All are held stable until awready.
  - On awvalid&&awready go to DATA and load beat_cnt=burst_len-1.
- DATA:
  - wvalid=s_valid, wdata=s_data, s_ready=wready. This is a combinational pass-through; outside DATA, s_ready=0 and wvalid=0.
  - wlast=(beat_cnt==0).
  - On wvalid&&wready: decrement beat_cnt. If wlast, go to RESP.
  - A stream stall (s_valid=0) inserts bubbles with no beat loss.
- RESP:
  - bready=1.
  - On bvalid: if bresp!=2'b00, set error. Then remaining -= burst_len and cur_addr += burst_len.
  - If remaining==0: go to IDLE, pulse done, drop busy the same cycle. Otherwise go to ADDR.
- Error does not abort the command: the remaining bursts are still issued.
- Arithmetic: cur_addr wraps modulo 2^ADDR_WIDTH. No 4 KB boundary splitting, because memory is word-addressed and small.
- Only one burst is outstanding. AW for burst N+1 is never issued before B of burst N.
- Ready-to-valid: awvalid never depends on awready. wvalid depends only on s_valid.

Decomposition:
- Package axi_master_pkg holds:
  - state enum (IDLE, ADDR, DATA, RESP);
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10;
  - a burst_len min() function.
- No sub-module: a single flat module.

Test Plan:
- Single burst: start_addr=0, total_beats=4, stream A5A5A5A5, 5A5A5A5A, 12345678, 87654321.
  - Expect one AW with awaddr=0, awlen=3.
  - wlast only on beat 4.
  - done one cycle after B. Slave readback returns the four words in order.
- Multi-burst: start_addr=0x100, total_beats=20, MAX_BURST=16.
  - Expect AW(0x100, awlen=15), then AW(0x110, awlen=3) only after the first B.
  - 20 W beats with wlast on beats 16 and 20; one done pulse.
- Backpressure:
  - awready held low 3 cycles: awaddr/awlen/awvalid stay stable.
  - wready toggling every other cycle and s_valid gaps: exactly 4 beats transferred, no duplication.
- Error: slave returns bresp=2'b10 on burst 1 of 2.
  - error=1 and the second burst is still issued.
  - done pulses; error stays 1 until the next start clears it.
- Zero length: total_beats=0 gives done the next cycle, no awvalid, busy stays 0. start during busy is ignored.
- Reset mid-burst: assert rst_n=0 after beat 2 of 4.
  - All outputs are 0 asynchronously; no done.
  - A new command after release completes normally.
